// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns single or INCR4 client requests into pipelined
// AHB-Lite transfers, handling slave wait states and the two-cycle ERROR response.
module ahb_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic        req,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic        req_burst4,
  input  logic [31:0] wdata,
  output logic        wdata_take,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_PIPE = 3'd2;
  localparam logic [2:0] S_LAST = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  logic [2:0]  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic        burst4_q, burst4_d;
  logic [1:0]  beat_q, beat_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        accept;
  logic        misaligned;
  logic        crosses_1k;
  logic        illegal;
  logic [11:0] span_end;
  logic [31:0] addr_inc;
  logic        data_phase;
  logic        err_first;

  assign accept     = (state_q == S_IDLE) && !busy_q && req;
  assign misaligned = ((req_size == 3'd1) && req_addr[0]) ||
                      ((req_size == 3'd2) && (req_addr[1:0] != 2'b00));
  // Four beats of 2^size bytes must end at or before the next 1KB line.
  assign span_end   = {2'b00, req_addr[9:0]} + (12'd4 << req_size);
  assign crosses_1k = req_burst4 && (span_end > 12'd1024);
  assign illegal    = (req_size > 3'd2) || misaligned || crosses_1k;

  assign addr_inc   = 32'd1 << hsize_q;
  assign data_phase = (state_q == S_PIPE) || (state_q == S_LAST);
  assign err_first  = data_phase && HRESP && !HREADY;

  // First ERROR cycle must already show IDLE, cancelling the pending SEQ beat.
  always_comb begin
    HTRANS = TR_IDLE;
    case (state_q)
      S_ADDR:  HTRANS = TR_NONSEQ;
      S_PIPE:  HTRANS = err_first ? TR_IDLE : TR_SEQ;
      default: HTRANS = TR_IDLE;
    endcase
  end

  assign wdata_take = hwrite_q && HREADY &&
                      ((state_q == S_ADDR) || ((state_q == S_PIPE) && !HRESP));

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    burst4_d = burst4_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    if (done_q) busy_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (illegal) begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d  = S_ADDR;
            haddr_d  = req_addr;
            hsize_d  = req_size;
            hwrite_d = req_write;
            burst4_d = req_burst4;
            beat_d   = 2'd0;
            busy_d   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          haddr_d = haddr_q + addr_inc;
          beat_d  = beat_q + 2'd1;
          if (hwrite_q) hwdata_d = wdata;
          state_d = burst4_q ? S_PIPE : S_LAST;
        end
      end
      S_PIPE, S_LAST: begin
        if (HRESP) begin
          if (HREADY) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = S_ERR2;
          end
        end else if (HREADY) begin
          if (!hwrite_q) begin
            rdata_d  = HRDATA;
            rvalid_d = 1'b1;
          end
          if (state_q == S_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            haddr_d = haddr_q + addr_inc;
            beat_d  = beat_q + 2'd1;
            if (hwrite_q) hwdata_d = wdata;
            state_d = (beat_q == 2'd3) ? S_LAST : S_PIPE;
          end
        end
      end
      S_ERR2: begin
        if (HREADY) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      haddr_q  <= 32'd0;
      hwdata_q <= 32'd0;
      hwrite_q <= 1'b0;
      hsize_q  <= 3'd0;
      burst4_q <= 1'b0;
      beat_q   <= 2'd0;
      busy_q   <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      burst4_q <= burst4_d;
      beat_q   <= beat_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign HADDR       = haddr_q;
  assign HWDATA      = hwdata_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = hsize_q;
  assign HBURST      = burst4_q ? 3'b011 : 3'b000;
  assign HPROT       = 4'b0011;
  assign HMASTLOCK   = 1'b0;
  assign busy        = busy_q;
  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: the bench plays both client and AHB slave,
// stepping cycle by cycle with hand-computed expectations.
module tb_ahb_master;

  logic        HCLK;
  logic        HRESETn;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic        req;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic        req_burst4;
  logic [31:0] wdata;
  logic        wdata_take;
  logic        busy;
  logic [31:0] rdata;
  logic        rvalid;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rv_tot   = 0;
  int take_tot = 0;
  int aph_tot  = 0;
  int snap;

  ahb_master dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .HRDATA      (HRDATA),
    .HADDR       (HADDR),
    .HWDATA      (HWDATA),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HPROT       (HPROT),
    .HMASTLOCK   (HMASTLOCK),
    .req         (req),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_burst4  (req_burst4),
    .wdata       (wdata),
    .wdata_take  (wdata_take),
    .busy        (busy),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .done        (done),
    .error       (error),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Running totals sampled mid-cycle; steps compare deltas.
  always @(negedge HCLK) begin
    if (rvalid) rv_tot <= rv_tot + 1;
    if (wdata_take) take_tot <= take_tot + 1;
    if ((HTRANS != 2'b00) && HREADY) aph_tot <= aph_tot + 1;
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic b4);
    req        = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_size   = size;
    req_burst4 = b4;
    settle();
    tick();
    req = 1'b0;
    settle();
  endtask

  task automatic try_illegal(input string tag, input logic [31:0] addr,
                             input logic [2:0] size, input logic b4);
    snap = aph_tot;
    issue(1'b0, addr, size, b4);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    chk({tag, "_done"},   32'(done),   32'h1);
    chk({tag, "_error"},  32'(error),  32'h1);
    chk({tag, "_busy"},   32'(busy),   32'h0);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'h0);
    chk({tag, "_aph"}, 32'(aph_tot - snap), 32'h0);
  endtask

  task automatic wait_done(input string tag, input int budget, output logic err_seen);
    logic seen;
    seen     = 1'b0;
    err_seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      settle();
      if (done) begin
        seen     = 1'b1;
        err_seen = error;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'h1);
  endtask

  initial begin
    logic e;
    HRESETn    = 1'b0;
    HREADY     = 1'b1;
    HRESP      = 1'b0;
    HRDATA     = 32'h0;
    req        = 1'b0;
    req_write  = 1'b0;
    req_addr   = 32'h0;
    req_size   = 3'd0;
    req_burst4 = 1'b0;
    wdata      = 32'h0;

    // Reset values
    tick();
    tick();
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_haddr",  HADDR,       32'h0);
    chk("rst_hwdata", HWDATA,      32'h0);
    chk("rst_hwrite", 32'(HWRITE), 32'h0);
    chk("rst_hsize",  32'(HSIZE),  32'h0);
    chk("rst_hburst", 32'(HBURST), 32'h0);
    chk("rst_hprot",  32'(HPROT),  32'h3);
    chk("rst_lock",   32'(HMASTLOCK), 32'h0);
    chk("rst_busy",   32'(busy),   32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_done",   32'(done),   32'h0);
    chk("rst_error",  32'(error),  32'h0);
    chk("rst_rdata",  rdata,       32'h0);
    HRESETn = 1'b1;
    tick();

    // Single word write 0x100 <- DEADBEEF
    wdata = 32'hDEAD_BEEF;
    chk("w1_busy_pre", 32'(busy), 32'h0);
    issue(1'b1, 32'h100, 3'd2, 1'b0);
    chk("w1_htrans", 32'(HTRANS), 32'h2);
    chk("w1_haddr",  HADDR,       32'h100);
    chk("w1_hwrite", 32'(HWRITE), 32'h1);
    chk("w1_hsize",  32'(HSIZE),  32'h2);
    chk("w1_hburst", 32'(HBURST), 32'h0);
    chk("w1_take",   32'(wdata_take), 32'h1);
    chk("w1_busy",   32'(busy),   32'h1);
    tick();
    wdata = 32'h0;
    settle();
    chk("w1_hwdata", HWDATA,      32'hDEAD_BEEF);
    chk("w1_htrans2", 32'(HTRANS), 32'h0);
    chk("w1_take2",  32'(wdata_take), 32'h0);
    chk("w1_done_early", 32'(done), 32'h0);
    tick();
    chk("w1_done",   32'(done),   32'h1);
    chk("w1_error",  32'(error),  32'h0);
    chk("w1_rvalid", 32'(rvalid), 32'h0);
    chk("w1_busy3",  32'(busy),   32'h1);
    tick();
    chk("w1_busy4",  32'(busy),   32'h0);
    chk("w1_done4",  32'(done),   32'h0);

    // INCR4 word read 0x200, slave returns 1..4
    snap = rv_tot;
    issue(1'b0, 32'h200, 3'd2, 1'b1);
    chk("r4_htrans1", 32'(HTRANS), 32'h2);
    chk("r4_haddr1",  HADDR,       32'h200);
    chk("r4_hburst",  32'(HBURST), 32'h3);
    chk("r4_take",    32'(wdata_take), 32'h0);
    tick(); HRDATA = 32'd1; settle();
    chk("r4_htrans2", 32'(HTRANS), 32'h3);
    chk("r4_haddr2",  HADDR,       32'h204);
    tick(); HRDATA = 32'd2; settle();
    chk("r4_htrans3", 32'(HTRANS), 32'h3);
    chk("r4_haddr3",  HADDR,       32'h208);
    chk("r4_rv1",     32'(rvalid), 32'h1);
    chk("r4_rd1",     rdata,       32'd1);
    tick(); HRDATA = 32'd3; settle();
    chk("r4_htrans4", 32'(HTRANS), 32'h3);
    chk("r4_haddr4",  HADDR,       32'h20C);
    chk("r4_rd2",     rdata,       32'd2);
    tick(); HRDATA = 32'd4; settle();
    chk("r4_htrans5", 32'(HTRANS), 32'h0);
    chk("r4_rd3",     rdata,       32'd3);
    chk("r4_done5",   32'(done),   32'h0);
    tick(); HRDATA = 32'd0; settle();
    chk("r4_rv4",     32'(rvalid), 32'h1);
    chk("r4_rd4",     rdata,       32'd4);
    chk("r4_done",    32'(done),   32'h1);
    chk("r4_error",   32'(error),  32'h0);
    tick();
    chk("r4_rv_cnt",  32'(rv_tot - snap), 32'd4);

    // INCR4 halfword write 0x40, two wait states on the second beat
    snap  = take_tot;
    wdata = 32'h1111_0000;
    issue(1'b1, 32'h40, 3'd1, 1'b1);
    chk("w4_haddr1", HADDR, 32'h40);
    chk("w4_hsize",  32'(HSIZE), 32'h1);
    chk("w4_take1",  32'(wdata_take), 32'h1);
    tick(); wdata = 32'h1111_0001; settle();
    chk("w4_haddr2", HADDR,  32'h42);
    chk("w4_hwd1",   HWDATA, 32'h1111_0000);
    tick(); wdata = 32'h1111_0002; HREADY = 1'b0; settle();
    chk("w4_haddr3_w1", HADDR, 32'h44);
    chk("w4_htrans_w1", 32'(HTRANS), 32'h3);
    chk("w4_hwd_w1",    HWDATA, 32'h1111_0001);
    chk("w4_take_w1",   32'(wdata_take), 32'h0);
    tick(); settle();
    chk("w4_haddr3_w2", HADDR, 32'h44);
    chk("w4_hwd_w2",    HWDATA, 32'h1111_0001);
    tick(); HREADY = 1'b1; settle();
    chk("w4_haddr3",    HADDR, 32'h44);
    chk("w4_take3",     32'(wdata_take), 32'h1);
    tick(); wdata = 32'h1111_0003; settle();
    chk("w4_haddr4",    HADDR, 32'h46);
    chk("w4_hwd3",      HWDATA, 32'h1111_0002);
    tick(); wdata = 32'h0; settle();
    chk("w4_htrans_last", 32'(HTRANS), 32'h0);
    chk("w4_hwd4",      HWDATA, 32'h1111_0003);
    tick();
    chk("w4_done",      32'(done), 32'h1);
    chk("w4_error",     32'(error), 32'h0);
    chk("w4_take_cnt",  32'(take_tot - snap), 32'd4);
    tick();

    // ERROR on beat 2 of INCR4 read at 0x300
    snap = rv_tot;
    issue(1'b0, 32'h300, 3'd2, 1'b1);
    chk("er_haddr1", HADDR, 32'h300);
    tick(); HRDATA = 32'h11; settle();
    chk("er_haddr2", HADDR, 32'h304);
    tick(); HRESP = 1'b1; HREADY = 1'b0; settle();
    chk("er_htrans_e1", 32'(HTRANS), 32'h0);
    chk("er_rd1",       rdata, 32'h11);
    tick(); HREADY = 1'b1; settle();
    chk("er_htrans_e2", 32'(HTRANS), 32'h0);
    chk("er_done_e2",   32'(done), 32'h0);
    tick(); HRESP = 1'b0; settle();
    chk("er_done",   32'(done),   32'h1);
    chk("er_error",  32'(error),  32'h1);
    chk("er_rvalid", 32'(rvalid), 32'h0);
    tick();
    chk("er_busy",   32'(busy),   32'h0);
    chk("er_rv_cnt", 32'(rv_tot - snap), 32'd1);

    // Illegal requests: no bus activity, done+error next cycle
    try_illegal("il_1k",    32'h3FC, 3'd2, 1'b1);
    try_illegal("il_align", 32'h101, 3'd2, 1'b0);
    try_illegal("il_half",  32'h041, 3'd1, 1'b0);
    try_illegal("il_size",  32'h000, 3'd3, 1'b0);

    // INCR4 word burst ending exactly on the 1KB line is legal
    issue(1'b0, 32'h3F0, 3'd2, 1'b1);
    chk("bd_htrans", 32'(HTRANS), 32'h2);
    chk("bd_haddr",  HADDR,       32'h3F0);
    wait_done("bd", 12, e);
    chk("bd_error", 32'(e), 32'h0);
    tick();

    // Reset during PIPE, then a clean single read
    issue(1'b0, 32'h200, 3'd2, 1'b1);
    tick(); settle();
    chk("rp_in_pipe", 32'(HTRANS), 32'h3);
    HRESETn = 1'b0;
    settle();
    chk("rp_htrans", 32'(HTRANS), 32'h0);
    chk("rp_haddr",  HADDR,       32'h0);
    chk("rp_hburst", 32'(HBURST), 32'h0);
    chk("rp_hsize",  32'(HSIZE),  32'h0);
    chk("rp_busy",   32'(busy),   32'h0);
    chk("rp_rvalid", 32'(rvalid), 32'h0);
    chk("rp_rdata",  rdata,       32'h0);
    tick();
    chk("rp_done",   32'(done),   32'h0);
    HRESETn = 1'b1;
    tick();
    issue(1'b0, 32'h80, 3'd2, 1'b0);
    chk("rp2_htrans", 32'(HTRANS), 32'h2);
    chk("rp2_haddr",  HADDR,       32'h80);
    tick(); HRDATA = 32'hCAFE_F00D; settle();
    tick(); HRDATA = 32'h0; settle();
    chk("rp2_rvalid", 32'(rvalid), 32'h1);
    chk("rp2_rdata",  rdata,       32'hCAFE_F00D);
    chk("rp2_done",   32'(done),   32'h1);
    chk("rp2_error",  32'(error),  32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
